btn_debounce_if: RTL and testbench
==================================

BTN_DEBOUNCE_IF -- requirements
Module: btn_debounce_if

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 50000: number of consecutive cycles a synchronized input must differ from its debounced state before that state updates; legal range 2..2^20.
REQ-002 The block SHALL have parameter NBTN, default 5: number of button inputs.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock for the block (CPU clock); every register uses its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port btn, input, NBTN bits: raw, asynchronous, bouncing button pins.
REQ-006 The block SHALL have port sel, input, 1 bit: register select from the bus bridge; 0 selects LEVEL, 1 selects EVENT.
REQ-007 The block SHALL have port we, input, 1 bit: bus write strobe, already qualified by the bridge address decode.
REQ-008 The block SHALL have port wdata, input, 32 bits: bus write data.
REQ-009 The block SHALL have port data, output, 32 bits: read data to the bridge.
REQ-010 The block SHALL have port irq, output, 1 bit: at least one EVENT bit is pending.

Function
REQ-011 Each btn bit SHALL pass through a 2-flop synchronizer (sync1 -> sync2); only sync2 is used downstream.
REQ-012 Each bit SHALL own a counter wide enough to hold DB_CYCLES-1 and a debounced state bit stable[i].
REQ-013 When sync2[i] == stable[i], counter[i] SHALL be cleared to 0 on the next edge.
REQ-014 When sync2[i] != stable[i] and counter[i] < DB_CYCLES-1, counter[i] SHALL increment by 1.
REQ-015 When sync2[i] != stable[i] and counter[i] == DB_CYCLES-1, stable[i] SHALL take sync2[i] and counter[i] SHALL clear to 0 on the same edge.
REQ-016 Any glitch shorter than DB_CYCLES cycles at sync2 SHALL leave stable unchanged; the counter restarts from 0 when the glitch ends.
REQ-017 Latency from a clean btn edge to the stable update SHALL be exactly 2 + DB_CYCLES clock edges.
REQ-018 The counter SHALL never wrap; it saturates by the transition in REQ-015.
REQ-019 A rising transition of stable[i] (0 -> 1 on an edge) SHALL set event[i] on that same edge; falling transitions SHALL NOT set any event bit.
REQ-020 When we=1 and sel=1, each event[i] with wdata[i]=1 SHALL clear on the next edge (write-1-to-clear); bits with wdata[i]=0 SHALL be unaffected.
REQ-021 If a set and a clear of the same event[i] occur on the same edge, the set SHALL win.
REQ-022 Writes with sel=0, and wdata bits above NBTN-1, SHALL have no effect.
REQ-023 The data output SHALL be combinational: sel=0 gives zero-extended stable; sel=1 gives zero-extended event; bits 31..NBTN are always 0.
REQ-024 The irq output SHALL be the registered-free OR-reduction of event.
REQ-025 Reads SHALL NOT have side effects.

Reset
REQ-026 While rst=1 at an edge, the block SHALL clear sync1, sync2, stable, all counters and event to 0; data then reads 0 and irq is 0.
REQ-027 Asserting rst mid-debounce SHALL discard the in-progress count; a button held through reset SHALL produce a stable rise, and hence an event, 2 + DB_CYCLES edges after rst deasserts.
REQ-028 rst SHALL take priority over we.

Verification (bench uses DB_CYCLES=4, NBTN=5)
REQ-029 Clean press: btn goes 00000 -> 00001 and is held; the bench SHALL check stable[0]=1 exactly 6 edges later, event=00001 on the same edge, and irq=1.
REQ-030 Bounce: btn[2] pulses high for 3 cycles, low for 1, then high and held; the bench SHALL check no stable change during the bounce and stable[2]=1 exactly 6 edges after the final rise.
REQ-031 W1C: with event=00101, a write of sel=1, we=1, wdata=0x00000004 SHALL leave event=00001 and irq=1; a write of wdata=0x1 then SHALL leave event=0 and irq=0.
REQ-032 Set/clear collision: a W1C of bit 3 on the same edge as the stable[3] rise SHALL leave event[3]=1.
REQ-033 Release: btn[0] goes 1 -> 0 and is held; the bench SHALL check stable[0]=0 after 6 edges with event unchanged. A read with sel=0 SHALL return 0x00000000 while a read with sel=1 returns the pending events.
REQ-034 Reset mid-count: btn[1] is held high and rst is pulsed on the 3rd counting cycle; the bench SHALL check all outputs are 0 after reset and stable[1]=1 exactly 6 edges after rst deasserts.

Source files
------------

// File: rtl/btn_debounce_if.sv
// Debounced push-button block with a bus-readable LEVEL register (debounced state)
// and a write-1-to-clear EVENT register latching rising edges; irq flags pending events.
module btn_debounce_if #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned NBTN      = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn,
    input  logic            sel,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     data,
    output logic            irq
);

    localparam int unsigned     CW     = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]   CntMax = CW'(DB_CYCLES - 1);

    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] stable_q, stable_d;
    logic [NBTN-1:0] event_q, event_d;
    logic [NBTN-1:0] rise, clr;
    logic [CW-1:0]   cnt_q [NBTN];
    logic [CW-1:0]   cnt_d [NBTN];

    // Upper write-data bits carry no register state.
    logic [31:0] unused_wdata;
    assign unused_wdata = wdata;

    // The counter only runs while the synchronized input disagrees with the debounced
    // state; reaching CntMax commits the new level and restarts from zero.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(NBTN); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // A new rising edge wins over a simultaneous write-1-to-clear.
    always_comb begin
        rise    = stable_d & ~stable_q;
        clr     = (we && sel) ? wdata[NBTN-1:0] : '0;
        event_d = (event_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            event_q  <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            event_q  <= event_d;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        data = sel ? 32'(event_q) : 32'(stable_q);
        irq  = |event_q;
    end

endmodule

// File: tb/tb_btn_debounce_if.sv
// Directed bench for btn_debounce_if with DB_CYCLES=4, NBTN=5: a table of per-edge
// vectors with hand-computed read data and irq, plus a hand-written reset-mid-count sequence.
module tb_btn_debounce_if;

    localparam int unsigned DB   = 4;
    localparam int unsigned NBTN = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NBTN-1:0] btn;
    logic            sel;
    logic            we;
    logic [31:0]     wdata;
    logic [31:0]     data;
    logic            irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btn_debounce_if #(
        .DB_CYCLES(DB),
        .NBTN     (NBTN)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .sel  (sel),
        .we   (we),
        .wdata(wdata),
        .data (data),
        .irq  (irq)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  btn;
        logic        sel;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [4:0] b, input logic s, input logic w,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ei);
        vec_t v;
        v.rst = r; v.btn = b; v.sel = s; v.we = w; v.wdata = wd;
        v.exp_data = ed; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; btn = '0; sel = 1'b0; we = 1'b0; wdata = '0;

        // Reset, with a write attempt that reset must override
        add(1, 5'b00000, 0, 0, 32'h0, 32'h0, 0);
        add(1, 5'b00000, 1, 1, 32'h0, 32'h0, 0);
        // Clean press of btn[0]: stable rises on the 6th edge
        for (int k = 0; k < 5; k++) add(0, 5'b00001, 0, 0, 32'h0, 32'h0, 0);
        add(0, 5'b00001, 0, 0, 32'h0, 32'h1, 1);
        add(0, 5'b00001, 1, 0, 32'h0, 32'h1, 1);
        // Bounce on btn[2]: high 3, low 1, then held high
        for (int k = 0; k < 3; k++) add(0, 5'b00101, 0, 0, 32'h0, 32'h1, 1);
        add(0, 5'b00001, 0, 0, 32'h0, 32'h1, 1);
        for (int k = 0; k < 5; k++) add(0, 5'b00101, 0, 0, 32'h0, 32'h1, 1);
        add(0, 5'b00101, 0, 0, 32'h0, 32'h5, 1);
        add(0, 5'b00101, 1, 0, 32'h0, 32'h5, 1);
        // Writes: sel=0 and upper bits ignored, then W1C of bit 2 and bit 0
        add(0, 5'b00101, 0, 1, 32'hFFFF_FFFF, 32'h5, 1);
        add(0, 5'b00101, 1, 1, 32'hFFFF_FFE0, 32'h5, 1);
        add(0, 5'b00101, 1, 1, 32'h4, 32'h1, 1);
        add(0, 5'b00101, 1, 1, 32'h1, 32'h0, 0);
        // Press btn[3]; W1C of bit 3 on the very edge stable[3] rises
        for (int k = 0; k < 5; k++) add(0, 5'b01101, 1, 0, 32'h0, 32'h0, 0);
        add(0, 5'b01101, 1, 1, 32'h8, 32'h8, 1);
        add(0, 5'b01101, 0, 0, 32'h0, 32'hD, 1);
        // Release all: falls set no events; repeated reads are side-effect free
        for (int k = 0; k < 5; k++) add(0, 5'b00000, 0, 0, 32'h0, 32'hD, 1);
        add(0, 5'b00000, 0, 0, 32'h0, 32'h0, 1);
        add(0, 5'b00000, 1, 0, 32'h0, 32'h8, 1);
        add(0, 5'b00000, 1, 0, 32'h0, 32'h8, 1);
        add(0, 5'b00000, 1, 1, 32'h8, 32'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; btn = vecs[i].btn; sel = vecs[i].sel;
            we = vecs[i].we; wdata = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Reset mid-count: btn[1] held, rst on the 3rd counting edge
        rst = 1'b0; we = 1'b0; wdata = '0; sel = 1'b0; btn = 5'b00010;
        for (int k = 0; k < 4; k++) tick();
        check("pre-reset level", data, 32'h0);
        rst = 1'b1; we = 1'b1; sel = 1'b1; wdata = 32'h2;
        tick();
        we = 1'b0;
        #1;
        check("reset event", data, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        sel = 1'b0;
        #1;
        check("reset level", data, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("post-reset 5 edges level", data, 32'h0);
        check("post-reset 5 edges irq", 32'(irq), 32'h0);
        tick();
        check("post-reset 6 edges level", data, 32'h2);
        check("post-reset 6 edges irq", 32'(irq), 32'h1);
        sel = 1'b1;
        #1;
        check("post-reset event", data, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
